// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single 1RW SRAM macro port: core side (A) has
// priority with a starvation guard for the boot loader (B); boot mode hands B the port.
module sram_port_arbiter #(
  parameter int unsigned AW       = 11,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          bcf,
  input  logic          a_req,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [31:0]   a_wdt,
  output logic          a_gnt,
  output logic          a_rvl,
  output logic [31:0]   a_rdt,
  input  logic          b_req,
  input  logic [3:0]    b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [31:0]   b_wdt,
  output logic          b_gnt,
  output logic          b_rvl,
  output logic [31:0]   b_rdt,
  output logic          boot_act,
  output logic          m_csb,
  output logic          m_web,
  output logic [3:0]    m_wmask,
  output logic [AW-1:0] m_adr,
  output logic [31:0]   m_din,
  input  logic [31:0]   m_dout
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    NORM    = 2'd0,
    DRAIN_B = 2'd1,
    BOOT    = 2'd2,
    DRAIN_N = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [CW-1:0]     wait_cnt_nxt;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_own;
  logic              pipe_empty;
  logic              starved;
  logic              rd_push;
  logic [3:0]        we_sel;

  assign pipe_empty = ~|tag_vld;
  assign starved    = (wait_cnt == CW'(MAX_WAIT));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= NORM;
    else       state <= state_nxt;
  end

  // Next-state: mode changes always pass through a drain of in-flight reads
  always_comb begin
    state_nxt = state;
    case (state)
      NORM:    if (bcf)        state_nxt = DRAIN_B;
      DRAIN_B: if (pipe_empty) state_nxt = BOOT;
      BOOT:    if (!bcf)       state_nxt = DRAIN_N;
      DRAIN_N: if (pipe_empty) state_nxt = NORM;
      default:                 state_nxt = NORM;
    endcase
  end

  // Grant decode; a pending mode switch suppresses all grants
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state)
      NORM: begin
        if (!bcf) begin
          if (b_req && (!a_req || starved)) b_gnt = 1'b1;
          else if (a_req)                   a_gnt = 1'b1;
        end
      end
      BOOT:    b_gnt = bcf & b_req;
      default: begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
      end
    endcase
  end

  // Macro drive from the winner, zeroed when idle
  always_comb begin
    we_sel = 4'h0;
    m_adr  = '0;
    m_din  = '0;
    if (a_gnt) begin
      we_sel = a_we;
      m_adr  = a_adr;
      m_din  = a_wdt;
    end else if (b_gnt) begin
      we_sel = b_we;
      m_adr  = b_adr;
      m_din  = b_wdt;
    end
  end

  assign m_csb   = ~(a_gnt | b_gnt);
  assign m_web   = ~|we_sel;
  assign m_wmask = we_sel;
  assign rd_push = (a_gnt | b_gnt) & ~|we_sel;

  // Consecutive denied-B count, only live in normal mode
  always_comb begin
    wait_cnt_nxt = '0;
    if ((state == NORM) && !bcf && b_req && !b_gnt)
      wait_cnt_nxt = starved ? wait_cnt : wait_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wait_cnt <= '0;
    else       wait_cnt <= wait_cnt_nxt;
  end

  // Owner tag pipeline aligned with the macro read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= RD_LAT'({tag_vld, rd_push});
      tag_own <= RD_LAT'({tag_own, b_gnt});
    end
  end

  // Read data capture and valid pulse per owner
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rvl <= 1'b0;
      b_rvl <= 1'b0;
      a_rdt <= '0;
      b_rdt <= '0;
    end else begin
      a_rvl <= 1'b0;
      b_rvl <= 1'b0;
      if (tag_vld[RD_LAT-1]) begin
        if (tag_own[RD_LAT-1]) begin
          b_rdt <= m_dout;
          b_rvl <= 1'b1;
        end else begin
          a_rdt <= m_dout;
          a_rvl <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) boot_act <= 1'b0;
    else       boot_act <= (state_nxt == BOOT);
  end

endmodule
